// File: rtl/pic_priority_resolver.sv
// IRR/ISR registers and rotating priority resolver of the PIC.
// Resolves the highest-priority unmasked request against the in-service levels.
module pic_priority_resolver (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ir,
   input  logic       ltim,
   input  logic [7:0] mask,
   input  logic       aeoi,
   input  logic       rot,
   input  logic       inta_first,
   input  logic       inta_last,
   input  logic       eoi,
   input  logic       seoi,
   input  logic       set_prio,
   input  logic [2:0] lvl,
   output logic [7:0] irr,
   output logic [7:0] isr,
   output logic       isprior,
   output logic [2:0] vec_id
);

   logic [7:0] ir_q, irr_q, irr_d, isr_q, isr_d;
   logic       isprior_q, isprior_d;
   logic [2:0] vec_id_q, vec_id_d, lp_q, lp_d, ack_lvl_q, ack_lvl_d;
   logic       ack_vld_q, ack_vld_d;

   logic [7:0] cand, cand_ord, isr_ord, edge_v, ack_mask, isr_clr;
   logic       win_found, blk_found, ack, aeoi_clr;
   logic [2:0] win_rank, blk_rank, win_lvl, blk_lvl;

   // Reorder so that bit k holds level lp+1+k: bit 0 is the highest priority.
   function automatic logic [7:0] prio_order(input logic [7:0] v, input logic [2:0] lp);
      logic [7:0] r;
      logic [2:0] idx;
      for (int k = 0; k < 8; k++) begin
         idx  = lp + 3'(k + 1);
         r[k] = v[idx];
      end
      return r;
   endfunction

   function automatic logic [2:0] first_rank(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (v[k]) r = 3'(k);
      end
      return r;
   endfunction

   always_comb begin
      cand      = irr_q & ~mask;
      cand_ord  = prio_order(cand, lp_q);
      isr_ord   = prio_order(isr_q, lp_q);
      win_found = |cand;
      blk_found = |isr_q;
      win_rank  = first_rank(cand_ord);
      blk_rank  = first_rank(isr_ord);
      win_lvl   = lp_q + 3'd1 + win_rank;
      blk_lvl   = lp_q + 3'd1 + blk_rank;
      ack       = inta_first & isprior_q;
      ack_mask  = ack ? (8'd1 << vec_id_q) : 8'd0;
      aeoi_clr  = inta_last & aeoi & ack_vld_q;
      edge_v    = ir & ~ir_q;
   end

   always_comb begin
      irr_d = ir & ~ack_mask & (irr_q | (ltim ? 8'hff : edge_v));

      isr_clr = 8'd0;
      if (aeoi_clr)         isr_clr = isr_clr | (8'd1 << ack_lvl_q);
      if (eoi && blk_found) isr_clr = isr_clr | (8'd1 << blk_lvl);
      if (seoi)             isr_clr = isr_clr | (8'd1 << lvl);
      // Clears first, then the acknowledge set, so a set wins on the same bit.
      isr_d = (isr_q & ~isr_clr) | ack_mask;

      // An equal level in service does not interrupt: strict rank comparison.
      isprior_d = win_found & (~blk_found | (win_rank < blk_rank));

      if (inta_first && !isprior_q) vec_id_d = 3'd7;
      else if (win_found)           vec_id_d = win_lvl;
      else                          vec_id_d = vec_id_q;

      ack_lvl_d = ack_lvl_q;
      ack_vld_d = ack_vld_q;
      if (inta_first) begin
         ack_lvl_d = vec_id_q;
         ack_vld_d = isprior_q;
      end

      if (seoi && rot)                    lp_d = lvl;
      else if (eoi && rot && blk_found)   lp_d = blk_lvl;
      else if (aeoi_clr && rot)           lp_d = ack_lvl_q;
      else if (set_prio)                  lp_d = lvl;
      else                                lp_d = lp_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q      <= 8'd0;
         irr_q     <= 8'd0;
         isr_q     <= 8'd0;
         isprior_q <= 1'b0;
         vec_id_q  <= 3'd0;
         lp_q      <= 3'd7;
         ack_lvl_q <= 3'd0;
         ack_vld_q <= 1'b0;
      end else begin
         ir_q      <= ir;
         irr_q     <= irr_d;
         isr_q     <= isr_d;
         isprior_q <= isprior_d;
         vec_id_q  <= vec_id_d;
         lp_q      <= lp_d;
         ack_lvl_q <= ack_lvl_d;
         ack_vld_q <= ack_vld_d;
      end
   end

   assign irr     = irr_q;
   assign isr     = isr_q;
   assign isprior = isprior_q;
   assign vec_id  = vec_id_q;

endmodule
